hack_rom_arbiter: RTL

Shares the single synchronous-read port of the Hack instruction ROM between two requesters: the CPU instruction fetch (primary) and a debug/loader read port (secondary). It multiplexes the ROM address, tags each 1-cycle-latency read with its owner, and returns the data with a valid strobe. Bounded-starvation fixed priority gives the CPU near-full bandwidth while guaranteeing debug progress. Sits between hack_cpu/debug UART and the ROM32K.

---
 rtl/hack_rom_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hack_rom_arbiter.sv
// ---------------------------------------------------------------------------
// hack_rom_arbiter
//
// Shares the single synchronous-read port of the Hack instruction ROM between
// the CPU instruction fetch (primary) and a debug/loader read port
// (secondary). Fixed priority favours the CPU. A streak counter bounds how
// long debug can be starved: once STARVE_LIMIT consecutive fetch grants have
// been issued while debug waited, debug gets exactly one grant.
//
// The ROM has one cycle of read latency. A grant in cycle t returns data and a
// one-cycle valid strobe to the same owner in cycle t+1.
//
// Ports:
//   clock       system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   f_req       CPU fetch request
//   f_addr      CPU fetch address (held while f_req & ~f_gnt)
//   f_gnt       fetch granted this cycle (combinational)
//   f_stall     f_req & ~f_gnt, CPU must hold its PC
//   f_valid     fetch data valid (registered)
//   f_data      fetch word, zero when f_valid is low
//   d_req       debug read request
//   d_addr      debug address (held while d_req & ~d_gnt)
//   d_gnt       debug granted this cycle (combinational)
//   d_valid     debug data valid (registered)
//   d_data      debug word, zero when d_valid is low
//   rom_addr    address to the ROM, sampled on the rising edge
//   rom_data    ROM output, valid the cycle after the address is sampled
//   starve_cnt  current streak count, zero-extended/truncated to 4 bits
// ---------------------------------------------------------------------------
module hack_rom_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_stall,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [3:0]        starve_cnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int EXT_W = (CNT_W > 4) ? CNT_W : 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  streak_q, streak_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              f_valid_q, d_valid_q;
  logic [EXT_W-1:0]  streak_ext;

  // Grants are suppressed while reset is held so that rom_addr reads zero
  // immediately on reset assertion, even if a requester is active.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      if (d_req && (!f_req || (streak_q == LIMIT))) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  assign f_stall = f_req & ~f_gnt;

  // When idle the ROM keeps seeing the last address rather than whatever is
  // floating on the request buses.
  always_comb begin
    if (f_gnt) begin
      rom_addr = f_addr;
    end else if (d_gnt) begin
      rom_addr = d_addr;
    end else begin
      rom_addr = last_addr_q;
    end
  end

  assign last_addr_d = rom_addr;

  // The streak only grows while debug is actually waiting behind a fetch; a
  // withdrawn debug request or a debug grant clears it.
  always_comb begin
    streak_d = streak_q;
    if (d_gnt || !d_req) begin
      streak_d = '0;
    end else if (f_gnt) begin
      if (streak_q != LIMIT) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak_q    <= '0;
      last_addr_q <= '0;
      f_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      last_addr_q <= last_addr_d;
      f_valid_q   <= f_gnt;
      d_valid_q   <= d_gnt;
    end
  end

  // The ROM output register is shared; the owner tag is simply which valid
  // strobe is high, and the other port is forced to zero.
  assign f_valid = f_valid_q;
  assign d_valid = d_valid_q;
  assign f_data  = f_valid_q ? rom_data : '0;
  assign d_data  = d_valid_q ? rom_data : '0;

  assign streak_ext = EXT_W'(streak_q);
  assign starve_cnt = streak_ext[3:0];

endmodule
